fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch stage between program memory and the instruction decoder of `proc`. It issues word-aligned 32-bit reads to a variable-latency memory port and splits each word into two 16-bit instructions. The instructions are buffered in a small FIFO and handed to the decoder with a valid/take handshake, together with each instruction's address. A redirect input (taken jump) flushes the queue and restarts fetching at the target. This block replaces the direct `pc`→ROM path.

## Interface
- `DEPTH`, 4: queue capacity in 16-bit entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0: first fetch address after reset; bit 0 ignored.

- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  reset, synchronous, active-low.
- `o_mem_req`  out  1  read request to program memory, registered.
- `o_mem_addr`  out  32  word address, bits [1:0] = 0, registered.
- `i_mem_ack`  in  1  read complete; sampled only while `o_mem_req`=1.
- `i_mem_data`  in  32  read data, valid with `i_mem_ack`. [15:0] is the halfword at addr; [31:16] is the halfword at addr+2.
- `o_ir`  out  16  head instruction; 16'h0 when empty.
- `o_pc`  out  32  address of `o_ir`; 32'h0 when empty.
- `o_valid`  out  1  queue non-empty.
- `i_take`  in  1  consumer pops the head at the edge where `o_valid & i_take`.
- `i_redirect`  in  1  flush and refetch.
- `i_redirect_pc`  in  32  target halfword address; bit 0 ignored.
- `o_level`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- **Registers:**
  - `fetch_pc`: next halfword address to fetch.
  - Circular queue of {ir, pc} entries, with read/write pointers wrapping modulo `DEPTH`.
  - `count`.
  - Fetch FSM.
- **FSM states:**
  - `IDLE`: no request outstanding.
  - `REQ`: request outstanding; its data will be kept.
  - `STALE`: request outstanding; its data will be discarded.
- **IDLE → REQ** when `count` ≤ `DEPTH`-2, checked on the pre-edge `count`. On that edge, drive `o_mem_req`=1 and `o_mem_addr`={fetch_pc[31:2],2'b00}.
- **REQ/STALE:** `o_mem_req` and `o_mem_addr` are held stable until `i_mem_ack`. A request is never withdrawn. Only one request is outstanding at a time.
- **Ack in REQ:**
  - If `fetch_pc[1]`=0: enqueue the low half with pc=addr, then the high half with pc=addr+2.
  - If `fetch_pc[1]`=1: enqueue only the high half with pc=addr+2.
  - `fetch_pc` ← addr+4.
  - The FSM goes to IDLE. It may re-arm at the next edge, subject to the level rule.
- **Ack in STALE:** discard the data and go to IDLE.
- **Redirect** (has priority over everything):
  - Queue is cleared: `count`←0, pointers←0.
  - `fetch_pc` ← {i_redirect_pc[31:1],1'b0}.
  - REQ → STALE. If ack arrives at the same edge, discard the data and go to IDLE.
  - `i_take` and any ack data at that edge are ignored.
- **Pop and enqueue at the same edge** are both performed. `count` is updated by +enq−pop.
- **Overflow is impossible:** a request is issued only with ≥ 2 free slots, and `count` cannot grow while the request is outstanding.
- **Address arithmetic** is 32-bit and wraps modulo 2^32.
- **Reset** (at an edge with `i_rst`=0, including mid-request):
  - FSM → IDLE, `o_mem_req`=0, `o_mem_addr`=0, `count`=0.
  - `o_valid`=0, `o_level`=0, `o_ir`=0, `o_pc`=0.
  - `fetch_pc`=`RESET_PC`.
  - An ack for a request abandoned by reset is ignored because `o_mem_req`=0.

## Timing
- `o_valid`, `o_ir`, `o_pc` and `o_level` are decoded from registers; there is no combinational input→output path.
- **Reset release:** `i_rst`=1 sampled at edge E0 → `o_mem_req`=1 after E0.
- **Memory to output:** ack sampled at edge E → entries visible after E.
- **Minimum redirect-to-valid latency** with a zero-wait memory (ack high whenever req is high) is 2 edges:
  - redirect edge → req asserted;
  - ack edge → `o_valid`=1.
- **Sustained throughput:** with a zero-wait memory and `i_take`=1, one request completes every 2 edges (IDLE → REQ → IDLE). That matches 1 instruction/cycle once primed.
- **Full / empty:**
  - `o_valid`=0 exactly when `count`=0.
  - No new request is issued while `count` > `DEPTH`-2.

## Test plan
- **Reset:** hold `i_rst`=0 for 3 cycles with `i_mem_ack`=1 → `o_mem_req`=0, `o_valid`=0, `o_level`=0. Release → `o_mem_req`=1, `o_mem_addr`=0 after the first edge.
- **Streaming:** zero-wait memory returns {addr+2, addr} as halfwords (word 0 = 32'h0002_0000), `i_take`=1 → `o_ir`/`o_pc` sequence 0000/0, 0002/2, 0004/4, …; addresses 0, 4, 8, … with no gaps or duplicates.
- **Backpressure:** `i_take`=0 → `o_level` reaches 4 and `o_mem_req` stays 0. Pop one → level 3, still no request. Pop a second → level 2, then a request is issued.
- **Unaligned redirect:** redirect to 32'h106 → `o_mem_addr`=32'h104. Exactly one entry, pc 32'h106, is enqueued; the next request is 32'h108.
- **Stale redirect:** memory with 3-cycle latency; redirect to 32'h40 one cycle after a request to 32'h8 is issued:
  - `o_mem_addr` stays 32'h8 until ack;
  - that data is dropped and `o_valid` stays 0;
  - the next request is 32'h40.
- **Simultaneous events:** redirect + `i_take` + ack at one edge with `o_level`=2 → `o_level`=0, ack data dropped, next request is the redirect target. Separately, pop + enqueue at one edge with level 1 → level 2 and order is preserved across pointer wrap.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Prefetch bus bundle: program-memory read port plus decoder-side queue head, take and redirect.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;
    logic [15:0]   ir;
    logic [31:0]   pc;
    logic          valid;
    logic          take;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [LW-1:0] level;

    modport master (
        output mem_req, mem_addr, ir, pc, valid, level,
        input  mem_ack, mem_data, take, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, ir, pc, valid, level,
        output mem_ack, mem_data, take, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch: word reads split into 16-bit entries; ack edge -> visible next cycle, redirect -> req next cycle.
// Backpressure: no new read while fewer than two slots are free; a read in flight is never withdrawn.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic           i_clk,
    input logic           i_rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, STALE} state_t;

    state_t        state, state_nxt;
    logic [31:1]   fetch_hw;
    logic [31:0]   mem_addr_q;
    logic [15:0]   ir_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_p1;
    logic [LW-1:0] count, enq_n;
    logic          issue, enq_lo, enq_hi, pop, valid;
    logic [31:0]   issue_addr;
    logic          unused_bits;

    // Halfword bit 0 of the redirect target carries no information.
    assign unused_bits = bus.redirect_pc[0];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        enq_lo    = 1'b0;
        enq_hi    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.redirect || count <= LW'(DEPTH - 2)) begin
                    state_nxt = REQ;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    state_nxt = bus.mem_ack ? IDLE : STALE;
                end else if (bus.mem_ack) begin
                    state_nxt = IDLE;
                    enq_lo    = ~fetch_hw[1];
                    enq_hi    = 1'b1;
                end
            end
            STALE: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign valid      = (count != '0);
    assign pop        = valid & bus.take & ~bus.redirect;
    assign enq_n      = LW'(enq_lo) + LW'(enq_hi);
    assign wr_ptr_p1  = wr_ptr + PW'(1);
    assign issue_addr = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : {fetch_hw[31:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fetch_hw   <= RESET_PC[31:1];
            mem_addr_q <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (issue) begin
                mem_addr_q <= issue_addr;
            end
            if (bus.redirect) begin
                fetch_hw <= bus.redirect_pc[31:1];
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (enq_hi) begin
                    fetch_hw <= mem_addr_q[31:1] + 31'd2;
                    wr_ptr   <= enq_lo ? wr_ptr + PW'(2) : wr_ptr_p1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + enq_n - LW'(pop);
            end
        end
    end

    // Entry storage needs no reset; count alone decides what is live.
    always_ff @(posedge i_clk) begin
        if (enq_lo) begin
            ir_q[wr_ptr] <= bus.mem_data[15:0];
            pc_q[wr_ptr] <= mem_addr_q;
        end
        if (enq_hi) begin
            ir_q[enq_lo ? wr_ptr_p1 : wr_ptr] <= bus.mem_data[31:16];
            pc_q[enq_lo ? wr_ptr_p1 : wr_ptr] <= mem_addr_q + 32'd2;
        end
    end

    assign bus.mem_req  = (state != IDLE);
    assign bus.mem_addr = mem_addr_q;
    assign bus.valid    = valid;
    assign bus.ir       = valid ? ir_q[rd_ptr] : 16'h0;
    assign bus.pc       = valid ? pc_q[rd_ptr] : 32'h0;
    assign bus.level    = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, backpressure, redirects, simultaneous events.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        zw;
    logic        man_ack;
    logic [31:0] man_data;
    int          checks = 0;
    int          errors = 0;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Zero-wait memory returns {addr+2, addr} as halfwords; otherwise the sequence drives ack/data by hand.
    assign bus.mem_ack  = zw ? bus.mem_req : man_ack;
    assign bus.mem_data = zw ? {bus.mem_addr[15:0] + 16'd2, bus.mem_addr[15:0]} : man_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b0;
        zw              = 1'b0;
        man_ack         = 1'b1;
        man_data        = 32'hDEAD_BEEF;
        bus.take        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset held with ack asserted
        repeat (3) tick();
        check("rst_req",   32'(bus.mem_req),  32'h0);
        check("rst_addr",  bus.mem_addr,      32'h0);
        check("rst_valid", 32'(bus.valid),    32'h0);
        check("rst_level", 32'(bus.level),    32'h0);
        check("rst_ir",    32'(bus.ir),       32'h0);
        check("rst_pc",    bus.pc,            32'h0);

        rst     = 1'b1;
        man_ack = 1'b0;
        tick();
        check("rel_req",  32'(bus.mem_req), 32'h1);
        check("rel_addr", bus.mem_addr,     32'h0);

        // Streaming with zero-wait memory
        zw       = 1'b1;
        bus.take = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stream_ir%0d", i), 32'(bus.ir), 32'(2 * i));
            check($sformatf("stream_pc%0d", i), bus.pc,      32'(2 * i));
            if (i % 2 == 1) begin
                check($sformatf("stream_req%0d", i),  32'(bus.mem_req), 32'h1);
                check($sformatf("stream_addr%0d", i), bus.mem_addr,     32'(2 * (i + 1)));
            end else begin
                check($sformatf("stream_req%0d", i), 32'(bus.mem_req), 32'h0);
            end
            tick();
        end

        // Backpressure
        bus.take = 1'b0;
        tick();
        check("bp_req",    32'(bus.mem_req), 32'h1);
        check("bp_addr",   bus.mem_addr,     32'h18);
        tick();
        tick();
        check("bp_full_level", 32'(bus.level),   32'h4);
        check("bp_full_req",   32'(bus.mem_req), 32'h0);
        check("bp_full_pc",    bus.pc,           32'h14);
        bus.take = 1'b1;
        tick();
        bus.take = 1'b0;
        check("bp_pop1_level", 32'(bus.level),   32'h3);
        check("bp_pop1_req",   32'(bus.mem_req), 32'h0);
        check("bp_pop1_pc",    bus.pc,           32'h16);
        tick();
        check("bp_hold_req",   32'(bus.mem_req), 32'h0);
        check("bp_hold_level", 32'(bus.level),   32'h3);
        bus.take = 1'b1;
        tick();
        bus.take = 1'b0;
        check("bp_pop2_level", 32'(bus.level),   32'h2);
        check("bp_pop2_req",   32'(bus.mem_req), 32'h0);
        check("bp_pop2_pc",    bus.pc,           32'h18);
        tick();
        check("bp_rearm_req",  32'(bus.mem_req), 32'h1);
        check("bp_rearm_addr", bus.mem_addr,     32'h1C);

        // Redirect + take + ack at level 2
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.take        = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.take     = 1'b0;
        zw           = 1'b0;
        man_ack      = 1'b0;
        check("sim_level", 32'(bus.level),   32'h0);
        check("sim_valid", 32'(bus.valid),   32'h0);
        check("sim_ir",    32'(bus.ir),      32'h0);
        check("sim_pc",    bus.pc,           32'h0);
        check("sim_req",   32'(bus.mem_req), 32'h0);
        tick();
        check("sim_next_req",  32'(bus.mem_req), 32'h1);
        check("sim_next_addr", bus.mem_addr,     32'h200);
        man_ack  = 1'b1;
        man_data = 32'hBBBB_AAAA;
        tick();
        man_ack = 1'b0;
        check("tgt_level", 32'(bus.level), 32'h2);
        check("tgt_ir",    32'(bus.ir),    32'hAAAA);
        check("tgt_pc",    bus.pc,         32'h200);

        // Pop and enqueue together, across pointer wrap
        bus.take = 1'b1;
        tick();
        check("wrap_a_level", 32'(bus.level), 32'h1);
        check("wrap_a_ir",    32'(bus.ir),    32'hBBBB);
        check("wrap_a_addr",  bus.mem_addr,   32'h204);
        man_ack  = 1'b1;
        man_data = 32'hDDDD_CCCC;
        tick();
        man_ack = 1'b0;
        check("wrap_b_level", 32'(bus.level), 32'h2);
        check("wrap_b_ir",    32'(bus.ir),    32'hCCCC);
        check("wrap_b_pc",    bus.pc,         32'h204);
        tick();
        check("wrap_c_ir",   32'(bus.ir),  32'hDDDD);
        check("wrap_c_addr", bus.mem_addr, 32'h208);
        man_ack  = 1'b1;
        man_data = 32'hFFFF_EEEE;
        tick();
        man_ack = 1'b0;
        check("wrap_d_level", 32'(bus.level), 32'h2);
        check("wrap_d_ir",    32'(bus.ir),    32'hEEEE);
        check("wrap_d_pc",    bus.pc,         32'h208);
        tick();
        bus.take = 1'b0;
        check("wrap_e_ir",   32'(bus.ir),  32'hFFFF);
        check("wrap_e_pc",   bus.pc,       32'h20A);
        check("wrap_e_addr", bus.mem_addr, 32'h20C);

        // Unaligned redirect issued while a read is in flight
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h106;
        tick();
        bus.redirect = 1'b0;
        check("ua_flush_level", 32'(bus.level),   32'h0);
        check("ua_hold_req",    32'(bus.mem_req), 32'h1);
        check("ua_hold_addr",   bus.mem_addr,     32'h20C);
        man_ack  = 1'b1;
        man_data = 32'h9999_9999;
        tick();
        man_ack = 1'b0;
        check("ua_drop_valid", 32'(bus.valid),   32'h0);
        check("ua_drop_req",   32'(bus.mem_req), 32'h0);
        tick();
        check("ua_addr", bus.mem_addr, 32'h104);
        man_ack  = 1'b1;
        man_data = 32'h7777_6666;
        tick();
        man_ack = 1'b0;
        check("ua_level", 32'(bus.level), 32'h1);
        check("ua_ir",    32'(bus.ir),    32'h7777);
        check("ua_pc",    bus.pc,         32'h106);
        tick();
        check("ua_next_req",  32'(bus.mem_req), 32'h1);
        check("ua_next_addr", bus.mem_addr,     32'h108);

        // Stale redirect with 3-cycle memory latency
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8;
        man_ack         = 1'b1;
        tick();
        bus.redirect = 1'b0;
        man_ack      = 1'b0;
        check("st_flush_level", 32'(bus.level), 32'h0);
        tick();
        check("st_req_addr", bus.mem_addr, 32'h8);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        check("st_hold1_addr",  bus.mem_addr,   32'h8);
        check("st_hold1_valid", 32'(bus.valid), 32'h0);
        tick();
        check("st_hold2_addr", bus.mem_addr,     32'h8);
        check("st_hold2_req",  32'(bus.mem_req), 32'h1);
        man_ack  = 1'b1;
        man_data = 32'h5555_4444;
        tick();
        man_ack = 1'b0;
        check("st_drop_valid", 32'(bus.valid),   32'h0);
        check("st_drop_req",   32'(bus.mem_req), 32'h0);
        tick();
        check("st_next_req",  32'(bus.mem_req), 32'h1);
        check("st_next_addr", bus.mem_addr,     32'h40);
        man_ack  = 1'b1;
        man_data = 32'h0042_0040;
        tick();
        man_ack = 1'b0;
        check("st_fill_level", 32'(bus.level), 32'h2);
        check("st_fill_ir",    32'(bus.ir),    32'h40);
        check("st_fill_pc",    bus.pc,         32'h40);
        bus.take = 1'b1;
        tick();
        bus.take = 1'b0;
        check("st_pop_ir",   32'(bus.ir),    32'h42);
        check("st_pop_pc",   bus.pc,         32'h42);
        check("st_pop_addr", bus.mem_addr,   32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
